// File: rtl/student_iis_handler.sv
// student_iis_handler: I2S master between the audio codec and the effect datapath.
// A free-running 10-bit frame counter derives MCLK/BCLK/LRCLK. It deserialises
// 16-bit stereo ADC samples and serialises the effect module's samples to the DAC.
//
// Output handshake: valid_strobe is a one-cycle, ready-less pulse. It is high for
// exactly the cycle in which Data_O_L/Data_O_R first show a new pair. The pair then
// stays stable until the next pulse, 1024 cycles later. A consumer that wants the
// pair simply registers Data_O_* while valid_strobe is high; there is no
// backpressure.
module student_iis_handler (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        AC_MCLK,
   output logic        AC_BCLK,
   output logic        AC_LRCLK,
   input  logic        AC_ADC_SDATA,
   output logic        AC_DAC_SDATA,
   input  logic [15:0] Data_I_L,
   input  logic [15:0] Data_I_R,
   output logic [15:0] Data_O_L,
   output logic [15:0] Data_O_R,
   output logic        valid_strobe
);

   logic [9:0]  cnt_q, cnt_d;
   logic [15:0] rx_l_q, rx_l_d;
   logic [15:0] rx_r_q, rx_r_d;
   logic [15:0] tx_l_q, tx_l_d;
   logic [15:0] tx_r_q, tx_r_d;
   logic [15:0] out_l_q, out_l_d;
   logic [15:0] out_r_q, out_r_d;
   logic        valid_q, valid_d;
   logic        dac_q, dac_d;

   // Slot currently in progress and the slot that starts at the next BCLK fall.
   logic [5:0]  slot;
   logic [5:0]  next_slot;
   // Bit of the transmit word that belongs to next_slot (MSB in the first data slot).
   logic [3:0]  bit_idx;

   // Codec clocks come straight from counter flops, so they cannot glitch.
   assign AC_MCLK      = cnt_q[1];
   assign AC_BCLK      = cnt_q[3];
   assign AC_LRCLK     = cnt_q[9];
   assign AC_DAC_SDATA = dac_q;
   assign Data_O_L     = out_l_q;
   assign Data_O_R     = out_r_q;
   assign valid_strobe = valid_q;

   // Next-state logic: counter, receive shifting, transmit load/drive, output update.
   always_comb begin
      cnt_d   = cnt_q + 10'd1;
      rx_l_d  = rx_l_q;
      rx_r_d  = rx_r_q;
      tx_l_d  = tx_l_q;
      tx_r_d  = tx_r_q;
      out_l_d = out_l_q;
      out_r_d = out_r_q;
      valid_d = 1'b0;
      dac_d   = dac_q;

      slot      = cnt_q[9:4];
      next_slot = slot + 6'd1;
      // next_slot - 1 == slot, and both data windows start on a multiple of 16 plus 1,
      // so the bit index within either window is simply the inverted slot LSBs.
      bit_idx   = ~slot[3:0];

      // Receive: sample on the BCLK rising edge inside the data slots.
      if (cnt_q[3:0] == 4'd8) begin
         if (slot >= 6'd1 && slot <= 6'd16) begin
            rx_l_d = {rx_l_q[14:0], AC_ADC_SDATA};
         end else if (slot >= 6'd33 && slot <= 6'd48) begin
            rx_r_d = {rx_r_q[14:0], AC_ADC_SDATA};
         end
      end

      // Transmit load at the end of slot 0, giving the effect 15 cycles after the strobe.
      if (cnt_q == 10'd15) begin
         tx_l_d = Data_I_L;
         tx_r_d = Data_I_R;
      end

      // Transmit drive: the DAC bit only changes on a BCLK falling edge.
      if (cnt_q[3:0] == 4'hF) begin
         dac_d = 1'b0;
         if (next_slot == 6'd1) begin
            // The left word is being loaded on this same edge.
            dac_d = Data_I_L[15];
         end else if (next_slot >= 6'd2 && next_slot <= 6'd16) begin
            dac_d = tx_l_q[bit_idx];
         end else if (next_slot >= 6'd33 && next_slot <= 6'd48) begin
            dac_d = tx_r_q[bit_idx];
         end
      end

      // Frame wrap: publish the completed pair and pulse the strobe for cnt == 0.
      if (cnt_q == 10'd1023) begin
         out_l_d = rx_l_q;
         out_r_d = rx_r_q;
         valid_d = 1'b1;
      end
   end

   // State registers; reset aborts the frame and clears every output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         rx_l_q  <= '0;
         rx_r_q  <= '0;
         tx_l_q  <= '0;
         tx_r_q  <= '0;
         out_l_q <= '0;
         out_r_q <= '0;
         valid_q <= 1'b0;
         dac_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         rx_l_q  <= rx_l_d;
         rx_r_q  <= rx_r_d;
         tx_l_q  <= tx_l_d;
         tx_r_q  <= tx_r_d;
         out_l_q <= out_l_d;
         out_r_q <= out_r_d;
         valid_q <= valid_d;
         dac_q   <= dac_d;
      end
   end

endmodule

// File: tb/tb_student_iis_handler.sv
// Testbench for student_iis_handler: a codec model drives I2S ADC data and captures
// the DAC stream; an effect model drives Data_I directly or as a loopback echo.
// Expected pairs go into queues, and a separate monitor checks the strobes.
module tb_student_iis_handler;

  logic        clk;
  logic        rst_ni;
  logic        AC_MCLK, AC_BCLK, AC_LRCLK;
  logic        AC_ADC_SDATA;
  logic        AC_DAC_SDATA;
  logic [15:0] Data_I_L, Data_I_R;
  logic [15:0] Data_O_L, Data_O_R;
  logic        valid_strobe;

  int errors = 0;
  int checks = 0;

  // Expected received pairs {left, right}, pushed at frame end, popped on strobe.
  logic [31:0] exp_q[$];
  // Planned ADC pairs; random pairs are used when this is empty.
  logic [31:0] adc_q[$];
  int          pushes = 0;
  int          pops   = 0;

  logic        lb_mode = 1'b0;
  logic [15:0] want_l  = '0;
  logic [15:0] want_r  = '0;

  // Rising edges since reset release; (edges % 1024) is the position in the frame.
  int edges;

  student_iis_handler dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .AC_MCLK      (AC_MCLK),
    .AC_BCLK      (AC_BCLK),
    .AC_LRCLK     (AC_LRCLK),
    .AC_ADC_SDATA (AC_ADC_SDATA),
    .AC_DAC_SDATA (AC_DAC_SDATA),
    .Data_I_L     (Data_I_L),
    .Data_I_R     (Data_I_R),
    .Data_O_L     (Data_O_L),
    .Data_O_R     (Data_O_R),
    .valid_strobe (valid_strobe)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) edges <= 0;
    else         edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- codec model (ADC drive, DAC capture) ----------------
  initial begin : codec
    logic [15:0] cur_l, cur_r, prev_l, prev_r, tx_l, tx_r;
    logic        cur_ok, prev_ok, tx_ok;
    logic [63:0] cap, exp_slots;
    int          ph, s;
    cur_l = '0; cur_r = '0; prev_l = '0; prev_r = '0; tx_l = '0; tx_r = '0;
    cur_ok = 1'b0; prev_ok = 1'b0; tx_ok = 1'b0;
    cap = '0; exp_slots = '0;
    AC_ADC_SDATA = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        cur_ok = 1'b0;
        prev_ok = 1'b0;
        tx_ok = 1'b0;
        AC_ADC_SDATA = ($urandom_range(0, 1) == 1);
      end else begin
        ph = edges % 1024;
        s  = ph / 16;
        if (ph == 0) begin
          prev_l = cur_l; prev_r = cur_r; prev_ok = cur_ok;
          if (adc_q.size() > 0) {cur_l, cur_r} = adc_q.pop_front();
          else                  {cur_l, cur_r} = $urandom;
          cur_ok = 1'b1;
          cap = '0;
        end
        // Philips I2S: MSB one BCLK after the LRCLK edge; other slots are junk.
        if (s >= 1 && s <= 16)       AC_ADC_SDATA = cur_l[16 - s];
        else if (s >= 33 && s <= 48) AC_ADC_SDATA = cur_r[48 - s];
        else                         AC_ADC_SDATA = ($urandom_range(0, 1) == 1);
        // What the DAC must carry this frame.
        if (ph == 15) begin
          if (lb_mode) begin
            tx_ok = prev_ok; tx_l = prev_l; tx_r = prev_r;
          end else begin
            tx_ok = 1'b1; tx_l = Data_I_L; tx_r = Data_I_R;
          end
        end
        // Capture the DAC in the middle of each slot (codec samples on BCLK rise).
        if ((ph % 16) == 8) cap[s] = AC_DAC_SDATA;
        if (ph == 1023) begin
          exp_q.push_back({cur_l, cur_r});
          pushes++;
          if (tx_ok) begin
            exp_slots = '0;
            for (int k = 1; k <= 16; k++)  exp_slots[k] = tx_l[16 - k];
            for (int k = 33; k <= 48; k++) exp_slots[k] = tx_r[48 - k];
            check("dac_frame", cap, exp_slots);
          end
          tx_ok = 1'b0;
        end
      end
    end
  end

  // ---------------- effect model driver ----------------
  initial begin : effect_drv
    int ph;
    Data_I_L = '0;
    Data_I_R = '0;
    forever begin
      @(negedge clk);
      ph = edges % 1024;
      if (rst_ni) begin
        if (lb_mode) begin
          // Registered echo two cycles after the strobe.
          if (ph == 2) begin
            Data_I_L = Data_O_L;
            Data_I_R = Data_O_R;
          end
        end else if (ph != 15) begin
          Data_I_L = want_l;
          Data_I_R = want_r;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [31:0] last, got;
    int          ph;
    last = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        check("reset_outs",
              64'({AC_MCLK, AC_BCLK, AC_LRCLK, AC_DAC_SDATA, valid_strobe, Data_O_L, Data_O_R}),
              64'd0);
        last = '0;
      end else begin
        ph = edges % 1024;
        check("mclk",   64'(AC_MCLK),  64'((edges % 4) >= 2));
        check("bclk",   64'(AC_BCLK),  64'((edges % 16) >= 8));
        check("lrclk",  64'(AC_LRCLK), 64'(ph >= 512));
        check("strobe_timing", 64'(valid_strobe), 64'(ph == 0 && edges != 0));
        if (valid_strobe) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", 64'(1), 64'(0));
          end else begin
            got  = {Data_O_L, Data_O_R};
            last = exp_q.pop_front();
            pops++;
            check("rx_pair", 64'(got), 64'(last));
          end
        end else begin
          check("data_o_stable", 64'({Data_O_L, Data_O_R}), 64'(last));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ph(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((edges % 1024) != target && n < 3000);
    check("wait_ph", 64'(edges % 1024), 64'(target));
  endtask

  task automatic run_frames(input int n);
    repeat (n * 1024) @(negedge clk);
  endtask

  initial begin : main
    rst_ni = 1'b0;
    adc_q.push_back({16'hA5C3, 16'h3C5A});
    adc_q.push_back({16'h0000, 16'hFFFF});
    adc_q.push_back({16'hFFFF, 16'h0000});
    want_l = 16'h8001;
    want_r = 16'h7FFE;
    repeat (3) @(posedge clk);
    #5 rst_ni = 1'b1;

    // Directed transmit pattern with random ADC data after the directed pairs.
    run_frames(5);

    // Edge values on transmit.
    wait_ph(100);
    want_l = 16'h0000; want_r = 16'hFFFF;
    run_frames(2);
    want_l = 16'hFFFF; want_r = 16'h0000;
    run_frames(2);

    // Random effect data changing at random points in the frame.
    for (int f = 0; f < 8; f++) begin
      wait_ph($urandom_range(20, 1000));
      want_l = 16'($urandom);
      want_r = 16'($urandom);
    end

    // Loopback.
    wait_ph(500);
    lb_mode = 1'b1;
    run_frames(20);

    // Mid-frame reset during a 0x1234 transfer.
    wait_ph(1000);
    adc_q.push_back({16'h1234, 16'h1234});
    wait_ph(600);
    #2 rst_ni = 1'b0;
    #1 check("midreset_outs",
             64'({AC_MCLK, AC_BCLK, AC_LRCLK, AC_DAC_SDATA, valid_strobe, Data_O_L, Data_O_R}),
             64'd0);
    @(posedge clk);
    @(posedge clk);
    #5 rst_ni = 1'b1;
    run_frames(3);

    wait_ph(300);
    check("leftover_exp", 64'(exp_q.size()), 64'd0);
    check("strobe_count", 64'(pops), 64'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
